accum_ctrl: RTL and testbench
=============================

// Module: accum_ctrl
// PURPOSE
//  Sequencer for the double-buffered 2-column accumulator memory.
//  - Accepts tile commands (number of K partial-sum passes per tile).
//  - Drives the accumulator's enable/mode/buffer-select on every accepted partial-sum beat.
//  - Ping-pongs between buffer 0 and 1 per tile; stalls the producer until the target buffer is drained.
//  - Sits between the systolic array output and accumulator_mem; the drain port feeds the activation/writeback stage.
// PARAMETERS
//  PASS_W  8   width of cmd_k_passes (max passes per tile = 2**PASS_W-1)
//  CNT_W   16  width of tile_count status counter
// PORTS
//  clk             in   1       clock
//  reset           in   1       synchronous, active-high reset
//  cmd_valid       in   1       tile command offered
//  cmd_ready       out  1       controller can accept a command (state IDLE)
//  cmd_k_passes    in   PASS_W  partial-sum beats in the tile; 0 is treated as 1
//  psum_valid      in   1       partial-sum beat present on the accumulator inputs
//  psum_ready      out  1       beat accepted this cycle when psum_valid & psum_ready
//  acc_enable      out  1       to accumulator enable
//  acc_mode        out  1       to accumulator_mode (0 = overwrite, 1 = add)
//  acc_buf_sel     out  1       to buffer_select
//  drain_valid     out  1       a completed buffer awaits readout
//  drain_buf       out  1       index of the oldest completed buffer
//  drain_ready     in   1       consumer has taken drain_buf; frees it
//  busy            out  1       state != IDLE or any buffer full
//  tile_count      out  CNT_W   completed tiles, wraps modulo 2**CNT_W
// BEHAVIOUR
//  Reset: state=IDLE, cur_buf=0, oldest=0, buf_full=2'b00, pass_cnt=0, tile_count=0.
//   While reset=1, every output is 0, cmd_ready included.
//  States:
//   IDLE     cmd_ready=1, psum_ready=0.
//            On cmd_valid: latch passes=max(cmd_k_passes,1); pass_cnt=0.
//            Go to ACCUM if !buf_full[cur_buf], else to WAIT_BUF.
//   WAIT_BUF cmd_ready=0, psum_ready=0.
//            Go to ACCUM the cycle after buf_full[cur_buf] reads 0 (registered check).
//   ACCUM    psum_ready=1; accept = psum_valid & psum_ready.
//  Accumulator drive (combinational, same cycle as accept):
//   acc_enable=accept; acc_mode=(pass_cnt!=0); acc_buf_sel=cur_buf.
//   When accept=0, acc_mode and acc_buf_sel are 0.
//  Per accept: pass_cnt+=1.
//   On the last accept (pass_cnt==passes-1): set buf_full[cur_buf], toggle cur_buf,
//   tile_count+=1, go to IDLE.
//  Drain: drain_valid=|buf_full (registered); drain_buf=oldest.
//   drain_valid rises the cycle after the last accept, aligned with the accumulator's valid_out.
//   On drain_valid & drain_ready: clear buf_full[oldest], toggle oldest.
//   drain_valid/drain_buf stay stable until taken.
//  Simultaneous events: a drain clear and a fill set in the same cycle always target different
//   buffers (a fill needs !full); apply both. A drain in the cycle WAIT_BUF samples does not
//   take effect until the next cycle (one-cycle release latency).
//  No backpressure toward the accumulator; psum_valid gaps insert idle cycles (acc_enable=0).
//  Reset mid-tile: partial tile discarded; next tile starts on buf 0 with mode 0.
//  Stray psum_valid in IDLE/WAIT_BUF is not accepted; it must be held by the producer.
// TESTING
//  1 cmd passes=3, 3 back-to-back beats -> acc_mode 0,1,1; acc_buf_sel 0,0,0;
//    next cycle drain_valid=1, drain_buf=0; tile_count=1.
//  2 Two 1-pass tiles, drain_ready=0 -> buffers 0 then 1 filled. Third cmd -> WAIT_BUF,
//    psum_ready=0. Pulse drain_ready: buf 0 freed, drain_buf->1;
//    psum_ready=1 two cycles later; beat uses acc_buf_sel=0, acc_mode=0.
//  3 cmd_k_passes=0 -> exactly one beat accepted, mode 0, tile completes.
//  4 passes=4 with psum_valid 1,0,1,0,1,1 -> acc_enable 1,0,1,0,1,1; mode 0,x,1,x,1,1;
//    done after 6th cycle.
//  5 reset after 1 of 4 beats -> outputs 0, buf_full=0; new 2-pass cmd -> sel 0, modes 0,1.
//  6 Drain accepted in the same cycle as another tile's last beat -> buf_full is 1 bit
//    throughout; drain_buf advances correctly.

Source files
------------

// File: rtl/accum_ctrl_if.sv
// Tile-command, partial-sum, accumulator-drive and drain signals of the accumulator sequencer.
// Handshakes: a transfer happens on a clock edge where valid & ready are both 1; valid holds its payload until taken.
interface accum_ctrl_if #(
   parameter int PASS_W = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [PASS_W-1:0] cmd_k_passes;
   logic              psum_valid;
   logic              psum_ready;
   logic              acc_enable;
   logic              acc_mode;
   logic              acc_buf_sel;
   logic              drain_valid;
   logic              drain_buf;
   logic              drain_ready;

   modport master (
      output cmd_valid, cmd_k_passes, psum_valid, drain_ready,
      input  cmd_ready, psum_ready, acc_enable, acc_mode, acc_buf_sel,
             drain_valid, drain_buf
   );

   modport slave (
      input  cmd_valid, cmd_k_passes, psum_valid, drain_ready,
      output cmd_ready, psum_ready, acc_enable, acc_mode, acc_buf_sel,
             drain_valid, drain_buf
   );
endinterface

// File: rtl/accum_ctrl.sv
// Sequencer for the double-buffered accumulator: accepts tile commands, drives the
// accumulator per partial-sum beat, ping-pongs buffers and holds the producer until a buffer drains.
module accum_ctrl #(
   parameter int PASS_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   accum_ctrl_if.slave      bus,
   output logic             busy,
   output logic [CNT_W-1:0] tile_count,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_BUF = 2'd1,
      ACCUM    = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic              cur_buf_q;
   logic              oldest_q;
   logic [1:0]        buf_full_q;
   logic [1:0]        buf_full_d;
   logic [PASS_W-1:0] passes_q;
   logic [PASS_W-1:0] pass_cnt_q;
   logic [CNT_W-1:0]  tile_cnt_q;

   logic cmd_take;
   logic accept;
   logic last_beat;
   logic drain_take;

   // Every output is forced low while reset is held, before the registers have cleared.
   assign bus.cmd_ready   = !reset && (state_q == IDLE);
   assign bus.psum_ready  = !reset && (state_q == ACCUM);
   assign bus.acc_enable  = accept;
   assign bus.acc_mode    = accept && (pass_cnt_q != '0);
   assign bus.acc_buf_sel = accept && cur_buf_q;
   assign bus.drain_valid = !reset && (|buf_full_q);
   assign bus.drain_buf   = !reset && oldest_q;
   assign busy            = !reset && ((state_q != IDLE) || (|buf_full_q));
   assign tile_count      = reset ? '0 : tile_cnt_q;
   assign state_dbg       = reset ? 2'b00 : state_q;

   assign drain_take = bus.drain_valid && bus.drain_ready;

   always_comb begin
      state_d   = state_q;
      cmd_take  = 1'b0;
      accept    = 1'b0;
      last_beat = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.cmd_ready && bus.cmd_valid) begin
               cmd_take = 1'b1;
               state_d  = buf_full_q[cur_buf_q] ? WAIT_BUF : ACCUM;
            end
         end
         WAIT_BUF: begin
            // A drain landing this cycle is seen next cycle: one-cycle release latency.
            if (!buf_full_q[cur_buf_q]) state_d = ACCUM;
         end
         ACCUM: begin
            accept    = bus.psum_ready && bus.psum_valid;
            last_beat = accept && (pass_cnt_q == passes_q - PASS_W'(1));
            if (last_beat) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Fill and drain can coincide only on different buffers, so both masks apply.
   always_comb begin
      buf_full_d = buf_full_q;
      if (drain_take) buf_full_d[oldest_q] = 1'b0;
      if (last_beat)  buf_full_d[cur_buf_q] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cur_buf_q  <= 1'b0;
         oldest_q   <= 1'b0;
         buf_full_q <= 2'b00;
         passes_q   <= '0;
         pass_cnt_q <= '0;
         tile_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         buf_full_q <= buf_full_d;
         if (cmd_take) begin
            passes_q   <= (bus.cmd_k_passes == '0) ? PASS_W'(1) : bus.cmd_k_passes;
            pass_cnt_q <= '0;
         end else if (accept) begin
            pass_cnt_q <= pass_cnt_q + PASS_W'(1);
         end
         if (last_beat) begin
            cur_buf_q  <= ~cur_buf_q;
            tile_cnt_q <= tile_cnt_q + CNT_W'(1);
         end
         if (drain_take) oldest_q <= ~oldest_q;
      end
   end

endmodule

// File: tb/tb_accum_ctrl.sv
// Directed, table-driven bench for accum_ctrl: one row per clock cycle, plus a
// hand-written reset-mid-tile sequence with a bounded wait on the drain.
module tb_accum_ctrl;

   logic        clk;
   logic        reset;
   logic        busy;
   logic [15:0] tile_count;
   logic [1:0]  state_dbg;

   accum_ctrl_if #(.PASS_W(8)) bus ();

   accum_ctrl #(.PASS_W(8), .CNT_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .busy       (busy),
      .tile_count (tile_count),
      .state_dbg  (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected bundle: {cmd_ready, psum_ready, acc_enable, acc_mode, acc_buf_sel,
   // drain_valid, drain_buf, busy, tile_count[15:0]}
   typedef struct {
      string       name;
      logic        rst;
      logic        cv;
      logic [7:0]  k;
      logic        pv;
      logic        dr;
      logic [23:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   n_applied = 0;
   int   n_fail    = 0;

   function automatic vec_t mk(string name, logic rst, logic cv, logic [7:0] k,
                               logic pv, logic dr, logic cr, logic pr, logic en,
                               logic md, logic sel, logic dv, logic db, logic bz,
                               logic [15:0] tc);
      vec_t v;
      v.name = name;
      v.rst  = rst;
      v.cv   = cv;
      v.k    = k;
      v.pv   = pv;
      v.dr   = dr;
      v.exp  = {cr, pr, en, md, sel, dv, db, bz, tc};
      return v;
   endfunction

   function automatic logic [23:0] observed();
      return {bus.cmd_ready, bus.psum_ready, bus.acc_enable, bus.acc_mode,
              bus.acc_buf_sel, bus.drain_valid, bus.drain_buf, busy, tile_count};
   endfunction

   task automatic drive(input logic rst, input logic cv, input logic [7:0] k,
                        input logic pv, input logic dr);
      reset            = rst;
      bus.cmd_valid    = cv;
      bus.cmd_k_passes = k;
      bus.psum_valid   = pv;
      bus.drain_ready  = dr;
   endtask

   // Inputs change just after a rising edge; outputs are checked at the falling edge.
   task automatic step(input vec_t v);
      logic [23:0] got;
      drive(v.rst, v.cv, v.k, v.pv, v.dr);
      @(negedge clk);
      got = observed();
      n_applied++;
      if (got !== v.exp) begin
         n_fail++;
         $display("FAIL %s: got cr,pr,en,md,sel,dv,db,busy=%b tc=%0d, expected %b tc=%0d",
                  v.name, got[23:16], got[15:0], v.exp[23:16], v.exp[15:0]);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_applied++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] exp_q[$];
      logic [1:0] e;
      bit         done;
      drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);

      //                 name       rst cv k  pv dr  cr pr en md sel dv db bz tc
      // reset: everything low, even with inputs active
      vecs.push_back(mk("rst0",     1, 1, 3, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk("rst1",     1, 1, 3, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0));
      // 3-pass tile, back-to-back beats into buffer 0
      vecs.push_back(mk("t1_cmd",   0, 1, 3, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk("t1_b0",    0, 0, 3, 1, 0,  0, 1, 1, 0, 0, 0, 0, 1, 0));
      vecs.push_back(mk("t1_b1",    0, 0, 3, 1, 0,  0, 1, 1, 1, 0, 0, 0, 1, 0));
      vecs.push_back(mk("t1_b2",    0, 0, 3, 1, 0,  0, 1, 1, 1, 0, 0, 0, 1, 0));
      vecs.push_back(mk("t1_done",  0, 0, 3, 0, 0,  1, 0, 0, 0, 0, 1, 0, 1, 1));
      vecs.push_back(mk("t1_drain", 0, 0, 3, 0, 1,  1, 0, 0, 0, 0, 1, 0, 1, 1));
      vecs.push_back(mk("t1_empty", 0, 0, 3, 0, 0,  1, 0, 0, 0, 0, 0, 1, 0, 1));
      // k=0 behaves as a single pass, into buffer 1
      vecs.push_back(mk("t3_cmd",   0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 0, 1));
      vecs.push_back(mk("t3_b0",    0, 0, 0, 1, 0,  0, 1, 1, 0, 1, 0, 1, 1, 1));
      vecs.push_back(mk("t3_done",  0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1, 1, 1, 2));
      vecs.push_back(mk("t3_drain", 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 1, 1, 1, 2));
      vecs.push_back(mk("t3_empty", 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 2));
      // 4 passes with psum_valid gaps 1,0,1,0,1,1
      vecs.push_back(mk("t4_cmd",   0, 1, 4, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 2));
      vecs.push_back(mk("t4_c0",    0, 0, 4, 1, 0,  0, 1, 1, 0, 0, 0, 0, 1, 2));
      vecs.push_back(mk("t4_c1",    0, 0, 4, 0, 0,  0, 1, 0, 0, 0, 0, 0, 1, 2));
      vecs.push_back(mk("t4_c2",    0, 0, 4, 1, 0,  0, 1, 1, 1, 0, 0, 0, 1, 2));
      vecs.push_back(mk("t4_c3",    0, 0, 4, 0, 0,  0, 1, 0, 0, 0, 0, 0, 1, 2));
      vecs.push_back(mk("t4_c4",    0, 0, 4, 1, 0,  0, 1, 1, 1, 0, 0, 0, 1, 2));
      vecs.push_back(mk("t4_c5",    0, 0, 4, 1, 0,  0, 1, 1, 1, 0, 0, 0, 1, 2));
      vecs.push_back(mk("t4_done",  0, 0, 4, 0, 0,  1, 0, 0, 0, 0, 1, 0, 1, 3));
      // buffer 0 left full; fill buffer 1, then a third command must wait
      vecs.push_back(mk("t2_cmd1",  0, 1, 1, 0, 0,  1, 0, 0, 0, 0, 1, 0, 1, 3));
      vecs.push_back(mk("t2_b1",    0, 0, 1, 1, 0,  0, 1, 1, 0, 1, 1, 0, 1, 3));
      vecs.push_back(mk("t2_cmd2",  0, 1, 1, 0, 0,  1, 0, 0, 0, 0, 1, 0, 1, 4));
      vecs.push_back(mk("t2_wait0", 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 1, 0, 1, 4));
      vecs.push_back(mk("t2_pulse", 0, 0, 1, 1, 1,  0, 0, 0, 0, 0, 1, 0, 1, 4));
      vecs.push_back(mk("t2_wait1", 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 1, 1, 1, 4));
      vecs.push_back(mk("t2_b0",    0, 0, 1, 1, 0,  0, 1, 1, 0, 0, 1, 1, 1, 4));
      // drain of buffer 0 coincides with the last beat into buffer 1
      vecs.push_back(mk("t6_dr1",   0, 0, 2, 0, 1,  1, 0, 0, 0, 0, 1, 1, 1, 5));
      vecs.push_back(mk("t6_cmd",   0, 1, 2, 0, 0,  1, 0, 0, 0, 0, 1, 0, 1, 5));
      vecs.push_back(mk("t6_b0",    0, 0, 2, 1, 0,  0, 1, 1, 0, 1, 1, 0, 1, 5));
      vecs.push_back(mk("t6_b1dr",  0, 0, 2, 1, 1,  0, 1, 1, 1, 1, 1, 0, 1, 5));
      vecs.push_back(mk("t6_after", 0, 0, 2, 0, 0,  1, 0, 0, 0, 0, 1, 1, 1, 6));
      vecs.push_back(mk("t6_dr",    0, 0, 2, 0, 1,  1, 0, 0, 0, 0, 1, 1, 1, 6));
      vecs.push_back(mk("t6_empty", 0, 0, 2, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 6));

      for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

      // Reset one beat into a 4-pass tile; the next tile restarts on buffer 0 in overwrite mode.
      step(mk("t5_cmd",   0, 1, 4, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 6));
      step(mk("t5_b0",    0, 0, 4, 1, 0,  0, 1, 1, 0, 0, 0, 0, 1, 6));
      step(mk("t5_rst",   1, 1, 4, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0));
      step(mk("t5_stray", 0, 0, 2, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0));
      step(mk("t5_cmd2",  0, 1, 2, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0));

      exp_q.push_back(2'b00);  // {acc_mode, acc_buf_sel} of beat 0
      exp_q.push_back(2'b10);  // beat 1
      done = 1'b0;
      for (int cyc = 0; cyc < 10 && !done; cyc++) begin
         drive(1'b0, 1'b0, 8'd2, 1'b1, 1'b0);
         @(negedge clk);
         if (bus.drain_valid) begin
            done = 1'b1;
         end else if (bus.acc_enable) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
            check("t5_beat_mode_sel", {14'd0, bus.acc_mode, bus.acc_buf_sel}, {14'd0, e});
         end
         if (!done) begin
            @(posedge clk);
            #1;
         end
      end
      check("t5_drain_seen", {15'd0, done}, 16'd1);
      check("t5_beats_left", 16'(exp_q.size()), 16'd0);
      check("t5_drain_buf", {15'd0, bus.drain_buf}, 16'd0);
      check("t5_tile_count", tile_count, 16'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
      $finish;
   end

endmodule
